// File: rtl/lsu_byte_master.sv
// Byte-serial load/store initiator: one core request becomes 1, 2 or 4
// little-endian byte accesses on a byte-wide RAM port, with sign/zero-extended load data.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for req; checks alignment, range and funct3 on acceptance
// XFER  | one RAM byte per cycle, cnt = current byte lane
// DONE  | one-cycle done pulse (with exception if the request was rejected)
module lsu_byte_master #(
    parameter int ram_width = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [2:0]           funct3,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 exception,
    output logic                 exc_cause,
    output logic [31:0]          rdata,
    output logic [ram_width:0]   mem_addr,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata
);

    localparam int AW = ram_width + 1;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t          r_state;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [AW-1:0]   r_base;
    logic [31:0]     r_wdata;
    logic [1:0]      r_cnt;
    logic [1:0]      r_nbm1;
    logic [31:0]     r_lanes;

    logic            w_legal;
    logic            w_misal;
    logic            w_oor;
    logic [1:0]      w_nbm1;
    logic [AW:0]     w_end;
    logic [1:0]      w_cnt_nxt;
    logic [31:0]     w_lanes;
    logic [31:0]     w_wdata_sh;
    logic [31:0]     w_ext;

    // Acceptance checks on the raw request inputs
    always_comb begin
        w_legal = ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101)) && !(we && funct3[2]);
        case (funct3[1:0])
            2'b00:   w_nbm1 = 2'd0;
            2'b01:   w_nbm1 = 2'd1;
            default: w_nbm1 = 2'd3;
        endcase
        w_misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        w_end   = {1'b0, addr[AW-1:0]} + {{(AW-1){1'b0}}, w_nbm1};
        w_oor   = (|addr[31:AW]) || w_end[AW];
    end

    // Lane image including the byte arriving this cycle, so the last byte
    // can be folded into rdata on the same edge that enters DONE.
    always_comb begin
        w_cnt_nxt  = r_cnt + 2'd1;
        w_lanes    = r_lanes;
        w_lanes[{r_cnt, 3'b000} +: 8] = mem_rdata;
        w_wdata_sh = r_wdata >> {w_cnt_nxt, 3'b000};
        case (r_funct3)
            3'b000:  w_ext = {{24{w_lanes[7]}}, w_lanes[7:0]};
            3'b001:  w_ext = {{16{w_lanes[15]}}, w_lanes[15:0]};
            3'b100:  w_ext = {24'd0, w_lanes[7:0]};
            3'b101:  w_ext = {16'd0, w_lanes[15:0]};
            default: w_ext = w_lanes;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_funct3  <= 3'd0;
            r_base    <= '0;
            r_wdata   <= 32'd0;
            r_cnt     <= 2'd0;
            r_nbm1    <= 2'd0;
            r_lanes   <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            exception <= 1'b0;
            exc_cause <= 1'b0;
            rdata     <= 32'd0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    exception <= 1'b0;
                    exc_cause <= 1'b0;
                    mem_we    <= 1'b0;
                    if (req) begin
                        r_we     <= we;
                        r_funct3 <= funct3;
                        r_base   <= addr[AW-1:0];
                        r_wdata  <= wdata;
                        r_nbm1   <= w_nbm1;
                        r_cnt    <= 2'd0;
                        r_lanes  <= 32'd0;
                        busy     <= 1'b1;
                        if (!w_legal || w_misal || w_oor) begin
                            r_state   <= DONE;
                            done      <= 1'b1;
                            exception <= 1'b1;
                            exc_cause <= !w_legal || !w_misal;
                        end else begin
                            r_state   <= XFER;
                            mem_addr  <= addr[AW-1:0];
                            mem_we    <= we;
                            mem_wdata <= wdata[7:0];
                        end
                    end
                end
                XFER: begin
                    r_lanes <= w_lanes;
                    if (r_cnt == r_nbm1) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        mem_we  <= 1'b0;
                        if (!r_we) begin
                            rdata <= w_ext;
                        end
                    end else begin
                        r_cnt     <= w_cnt_nxt;
                        mem_addr  <= r_base + {{(AW-2){1'b0}}, w_cnt_nxt};
                        mem_wdata <= w_wdata_sh[7:0];
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    exception <= 1'b0;
                    exc_cause <= 1'b0;
                end
            endcase
        end
    end

endmodule
